// File: rtl/ap_ctrl_perf_pkg.sv
// Shared types for the ap_ctrl performance monitor: channel FSM states,
// readback selector encodings and the record layout for the default build.
package ap_ctrl_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_WAIT_CONT = 2'd2
  } ch_state_e;

  typedef enum logic [1:0] {
    SEL_TXN_CNT   = 2'd0,
    SEL_MAX_LAT   = 2'd1,
    SEL_BUSY_CNT  = 2'd2,
    SEL_STALL_CNT = 2'd3
  } rd_sel_e;

  localparam int DEF_CH_W  = 2;
  localparam int DEF_CNT_W = 32;

  // Record as seen on rec_data with N_CH=4, CNT_W=32; MSB first.
  typedef struct packed {
    logic [DEF_CH_W-1:0]  ch;
    logic [DEF_CNT_W-1:0] start_ts;
    logic [DEF_CNT_W-1:0] lat;
  } perf_rec_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ap_ctrl_perf_chan.sv
// One monitored ap_ctrl channel: IDLE/BUSY/WAIT_CONT tracker, saturating
// statistics and a single pending-record slot emptied by the top's arbiter.
module ap_ctrl_perf_chan
  import ap_ctrl_perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frozen,
  input  logic             ap_start,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic [CNT_W-1:0] ts,
  input  logic             slot_clr,
  output logic             slot_vld,
  output logic [CNT_W-1:0] slot_start_ts,
  output logic [CNT_W-1:0] slot_lat,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] max_lat,
  output logic [CNT_W-1:0] busy_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             drop
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] start_ts_q, start_ts_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
  logic [CNT_W-1:0] max_lat_q, max_lat_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             slot_vld_q, slot_vld_d;
  logic [CNT_W-1:0] slot_start_ts_q, slot_start_ts_d;
  logic [CNT_W-1:0] slot_lat_q, slot_lat_d;
  logic             done_evt;
  logic [CNT_W-1:0] evt_start_ts, evt_lat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d         = state_q;
    start_ts_d      = start_ts_q;
    txn_cnt_d       = txn_cnt_q;
    max_lat_d       = max_lat_q;
    busy_cnt_d      = busy_cnt_q;
    stall_cnt_d     = stall_cnt_q;
    slot_vld_d      = slot_vld_q & ~slot_clr;
    slot_start_ts_d = slot_start_ts_q;
    slot_lat_d      = slot_lat_q;
    done_evt        = 1'b0;
    evt_start_ts    = start_ts_q;
    evt_lat         = '0;
    drop            = 1'b0;

    if (!frozen) begin
      case (state_q)
        ST_IDLE: begin
          if (ap_start && ap_done) begin
            done_evt     = 1'b1;
            evt_start_ts = ts;
            state_d      = ap_continue ? ST_IDLE : ST_WAIT_CONT;
          end else if (ap_start) begin
            state_d    = ST_BUSY;
            start_ts_d = ts;
          end
        end
        ST_BUSY: begin
          busy_cnt_d = sat_inc(busy_cnt_q);
          if (ap_done) begin
            done_evt = 1'b1;
            evt_lat  = ts - start_ts_q;
            state_d  = ap_continue ? ST_IDLE : ST_WAIT_CONT;
          end
        end
        ST_WAIT_CONT: begin
          stall_cnt_d = sat_inc(stall_cnt_q);
          if (ap_continue) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (done_evt) begin
        txn_cnt_d = sat_inc(txn_cnt_q);
        if (evt_lat > max_lat_q) max_lat_d = evt_lat;
        // A slot leaving this cycle can take the new record; otherwise it is lost.
        if (slot_vld_q && !slot_clr) begin
          drop = 1'b1;
        end else begin
          slot_vld_d      = 1'b1;
          slot_start_ts_d = evt_start_ts;
          slot_lat_d      = evt_lat;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      start_ts_q      <= '0;
      txn_cnt_q       <= '0;
      max_lat_q       <= '0;
      busy_cnt_q      <= '0;
      stall_cnt_q     <= '0;
      slot_vld_q      <= 1'b0;
      slot_start_ts_q <= '0;
      slot_lat_q      <= '0;
    end else begin
      state_q         <= state_d;
      start_ts_q      <= start_ts_d;
      txn_cnt_q       <= txn_cnt_d;
      max_lat_q       <= max_lat_d;
      busy_cnt_q      <= busy_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
      slot_vld_q      <= slot_vld_d;
      slot_start_ts_q <= slot_start_ts_d;
      slot_lat_q      <= slot_lat_d;
    end
  end

  assign slot_vld      = slot_vld_q;
  assign slot_start_ts = slot_start_ts_q;
  assign slot_lat      = slot_lat_q;
  assign txn_cnt       = txn_cnt_q;
  assign max_lat       = max_lat_q;
  assign busy_cnt      = busy_cnt_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: rtl/ap_ctrl_perf_fifo.sv
// Generic first-word-fall-through FIFO; pop_dat valid whenever !empty.
// Push while full is accepted only when a pop happens in the same cycle.
module ap_ctrl_perf_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    pop_dat  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl performance monitor: completion records reach rec_valid
// 2 cycles after ap_done (slot -> round-robin -> FWFT FIFO); rec_ready backpressures.
module ap_ctrl_perf_monitor
  import ap_ctrl_perf_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int CH_W      = ch_width(N_CH),
  localparam int REC_W     = CH_W + 2 * CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             finish,
  input  logic [N_CH-1:0]  ap_start,
  input  logic [N_CH-1:0]  ap_done,
  input  logic [N_CH-1:0]  ap_continue,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [REC_W-1:0] rec_data,
  input  logic [CH_W-1:0]  rd_ch,
  input  logic [1:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             ovf,
  output logic             frozen
);

  logic [CNT_W-1:0] ts_q, ts_d;
  logic             frozen_q, frozen_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N_CH-1:0]  slot_vld, slot_clr, drop;
  logic [CNT_W-1:0] slot_start_ts [N_CH];
  logic [CNT_W-1:0] slot_lat      [N_CH];
  logic [CNT_W-1:0] txn_cnt       [N_CH];
  logic [CNT_W-1:0] max_lat       [N_CH];
  logic [CNT_W-1:0] busy_cnt      [N_CH];
  logic [CNT_W-1:0] stall_cnt     [N_CH];

  logic             gnt_vld;
  logic [CH_W-1:0]  gnt_idx, arb_idx;
  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [REC_W-1:0] push_rec;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ap_ctrl_perf_chan #(.CNT_W(CNT_W)) u_chan (
      .clock         (clock),
      .reset         (reset),
      .frozen        (frozen_q),
      .ap_start      (ap_start[i]),
      .ap_done       (ap_done[i]),
      .ap_continue   (ap_continue[i]),
      .ts            (ts_q),
      .slot_clr      (slot_clr[i]),
      .slot_vld      (slot_vld[i]),
      .slot_start_ts (slot_start_ts[i]),
      .slot_lat      (slot_lat[i]),
      .txn_cnt       (txn_cnt[i]),
      .max_lat       (max_lat[i]),
      .busy_cnt      (busy_cnt[i]),
      .stall_cnt     (stall_cnt[i]),
      .drop          (drop[i])
    );
  end

  // Round-robin search starting at rr_ptr_q; pointer moves past the winner.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    arb_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      arb_idx = CH_W'((int'(rr_ptr_q) + k) % N_CH);
      if (!gnt_vld && slot_vld[arb_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = arb_idx;
      end
    end
    rec_valid = ~fifo_empty;
    fifo_pop  = rec_valid && rec_ready;
    fifo_push = gnt_vld && (!fifo_full || fifo_pop);
    slot_clr  = '0;
    if (fifo_push) slot_clr[gnt_idx] = 1'b1;
    rr_ptr_d  = fifo_push ? CH_W'((int'(gnt_idx) + 1) % N_CH) : rr_ptr_q;
    push_rec  = {gnt_idx, slot_start_ts[gnt_idx], slot_lat[gnt_idx]};
  end

  always_comb begin
    ts_d      = ts_q + CNT_W'(1);
    frozen_d  = frozen_q | finish;
    ovf_d     = ovf_q | (|drop);
    rd_data_d = '0;
    if (int'(rd_ch) < N_CH) begin
      case (rd_sel_e'(rd_sel))
        SEL_TXN_CNT:   rd_data_d = txn_cnt[rd_ch];
        SEL_MAX_LAT:   rd_data_d = max_lat[rd_ch];
        SEL_BUSY_CNT:  rd_data_d = busy_cnt[rd_ch];
        SEL_STALL_CNT: rd_data_d = stall_cnt[rd_ch];
        default:       rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q      <= '0;
      frozen_q  <= 1'b0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      ts_q      <= ts_d;
      frozen_q  <= frozen_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  ap_ctrl_perf_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (push_rec),
    .pop      (fifo_pop),
    .pop_dat  (rec_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;
  assign frozen  = frozen_q;

endmodule

// File: doc/ap_ctrl_perf_monitor.md
AP_CTRL_PERF_MONITOR -- requirements
Module: ap_ctrl_perf_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of monitored ap_ctrl channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of every counter, timestamp and latency field.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: record FIFO depth, power of two >= 2.
REQ-004 clock  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 finish  in  1  end of test; freezes statistics.
REQ-007 ap_start  in  N_CH  per-channel ap_start.
REQ-008 ap_done  in  N_CH  per-channel ap_done.
REQ-009 ap_continue  in  N_CH  per-channel ap_continue; tie to 1 for non-dataflow modules.
REQ-010 rec_valid  out  1  record available.
REQ-011 rec_ready  in  1  record consumed when high with rec_valid.
REQ-012 rec_data  out  CH_W+2*CNT_W  {channel, start timestamp, latency}; CH_W=max(1,clog2(N_CH)).
REQ-013 rd_ch  in  CH_W  statistics readback channel.
REQ-014 rd_sel  in  2  0=transaction count, 1=max latency, 2=busy cycles, 3=stall cycles.
REQ-015 rd_data  out  CNT_W  registered readback.
REQ-016 ovf  out  1  sticky: a record was dropped.
REQ-017 frozen  out  1  finish has been seen.

Function
REQ-018 SHALL keep a free-running CNT_W timestamp, +1 per cycle, wrapping at 2^CNT_W; latency computed modulo 2^CNT_W.
REQ-019 Per channel SHALL run FSM IDLE/BUSY/WAIT_CONT.
REQ-020 IDLE: ap_start=1 & ap_done=0 -> BUSY, capture start_ts=timestamp.
REQ-021 IDLE: ap_start=1 & ap_done=1 same cycle -> completed transaction, latency 0, next state per REQ-023.
REQ-022 BUSY: busy counter +1 per cycle; ap_done=1 -> latency=timestamp-start_ts.
REQ-023 On completion: ap_continue=1 -> IDLE; ap_continue=0 -> WAIT_CONT.
REQ-024 WAIT_CONT: stall counter +1 per cycle; ap_continue=1 -> IDLE; ap_done/ap_start ignored until then.
REQ-025 Each completion SHALL increment transaction count and update max latency if larger.
REQ-026 All statistics counters SHALL saturate at 2^CNT_W-1.
REQ-027 Each completion SHALL load a per-channel pending record slot; slot already full -> new record dropped, ovf=1.
REQ-028 Round-robin arbiter SHALL move one pending slot per cycle into FIFO when not full; pointer advances past granted channel.
REQ-029 FIFO full -> slots hold; no loss until a slot is overwritten (REQ-027).
REQ-030 rec_valid=FIFO non-empty; first-word fall-through; push and pop in same cycle when full allowed.
REQ-031 rd_data SHALL equal selected counter one cycle after rd_ch/rd_sel; rd_ch>=N_CH -> 0.
REQ-032 finish=1 -> frozen=1 next cycle; counters, FSMs, slot loading stop; FIFO still drains.
REQ-033 Latency of completion to rec_valid with empty FIFO and no contention: 2 cycles.

Reset
REQ-034 reset SHALL clear timestamp, all counters, slots, FIFO, arbiter pointer to 0; FSMs IDLE; rec_valid, ovf, frozen, rd_data = 0.
REQ-035 reset mid-transaction SHALL discard in-flight transactions without emitting records.

Structure
REQ-036 Package ap_ctrl_perf_pkg SHALL hold the FSM state enum, rd_sel encodings and record struct.
REQ-037 One sub-module ap_ctrl_perf_chan SHALL implement per-channel FSM, counters and pending slot; top instantiates N_CH copies, arbiter and FIFO.

Verification
REQ-038 ch0 start@ts=10, done@ts=17, continue=1 -> record {0,10,7}; count=1, max=7, busy=7.
REQ-039 ch1 done with continue=0 for 5 cycles -> stall=5; next start ignored until continue=1.
REQ-040 ch0..3 done same cycle, FIFO empty -> records ch0,ch1,ch2,ch3 on consecutive cycles, ovf=0.
REQ-041 rec_ready=0, FIFO_DEPTH=16, 20 ch0 completions -> 16 FIFO + 1 slot kept, ovf=1.
REQ-042 start and done same cycle in IDLE -> record latency 0, count+1.
REQ-043 finish=1 while ch2 BUSY -> frozen=1, ch2 counters static, queued records still drain.
